// File: rtl/life_frame_scheduler.sv
// life_frame_scheduler
// Sequences the WS2812B refresh of a Game-of-Life board: per pixel it fetches
// the cell colour, loads the shift register and waits out the serial
// transmission; after the last pixel it holds the line idle for the latch time
// and decides whether the datapath should commit the next generation.
`timescale 1ns/1ps

module life_frame_scheduler #(
  parameter int NUM_PIXELS     = 64,
  parameter int PIXEL_CYCLES   = 384,
  parameter int LATCH_CYCLES   = 1200,
  parameter int FRAMES_PER_GEN = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        step,
  output logic [5:0]  pixel,
  output logic [4:0]  frame,
  output logic        load_sreg,
  output logic        transmit_pixel,
  output logic        latching,
  output logic        frame_done,
  output logic        commit_gen,
  output logic [15:0] gen_count
);

  localparam int CNT_MAX = (PIXEL_CYCLES > LATCH_CYCLES) ? PIXEL_CYCLES : LATCH_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int GF_W    = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;

  localparam logic [CNT_W-1:0] SEND_LAST  = CNT_W'(PIXEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [5:0]       PIXEL_LAST = 6'(NUM_PIXELS - 1);
  localparam logic [GF_W-1:0]  GF_LAST    = GF_W'(FRAMES_PER_GEN - 1);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    LOAD   = 3'd1,
    SEND   = 3'd2,
    LATCH  = 3'd3,
    COMMIT = 3'd4
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [GF_W-1:0]  gen_frames;
  logic             step_pending;
  logic             send_end;
  logic             latch_end;
  logic             commit_now;

  // Next values of the registered outputs, decoded from the upcoming state
  logic load_sreg_d;
  logic transmit_pixel_d;
  logic latching_d;
  logic frame_done_d;
  logic commit_gen_d;

  // State register and the shared SEND/LATCH cycle counter
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state <= FETCH;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic, including the end-of-frame commit decision
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_next = state;
    cnt_next   = cnt;
    send_end   = 1'b0;
    latch_end  = 1'b0;
    commit_now = 1'b0;
    unique case (state)
      FETCH: state_next = LOAD;
      LOAD: begin
        state_next = SEND;
        cnt_next   = '0;
      end
      SEND: begin
        if (cnt == SEND_LAST) begin
          send_end   = 1'b1;
          cnt_next   = '0;
          state_next = (pixel == PIXEL_LAST) ? LATCH : FETCH;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      LATCH: begin
        if (cnt == LATCH_LAST) begin
          latch_end  = 1'b1;
          cnt_next   = '0;
          commit_now = (run && (gen_frames == GF_LAST)) || step_pending || step;
          state_next = commit_now ? COMMIT : FETCH;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      COMMIT: state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  // Output decode from the upcoming state so the output flops align with it
  always_comb begin
    load_sreg_d      = (state_next == LOAD);
    transmit_pixel_d = (state_next == SEND) && (state != SEND);
    latching_d       = (state_next == LATCH);
    frame_done_d     = (state_next == LATCH) && (cnt_next == LATCH_LAST);
    commit_gen_d     = (state_next == COMMIT);
  end

  // Output register: no combinational path from run/step to any port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_sreg      <= 1'b0;
      transmit_pixel <= 1'b0;
      latching       <= 1'b0;
      frame_done     <= 1'b0;
      commit_gen     <= 1'b0;
    end else begin
      load_sreg      <= load_sreg_d;
      transmit_pixel <= transmit_pixel_d;
      latching       <= latching_d;
      frame_done     <= frame_done_d;
      commit_gen     <= commit_gen_d;
    end
  end

  // Pixel/frame addressing, generation bookkeeping and step capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel        <= '0;
      frame        <= '0;
      gen_count    <= '0;
      gen_frames   <= '0;
      step_pending <= 1'b0;
    end else begin
      if (send_end && (pixel != PIXEL_LAST)) begin
        pixel <= pixel + 6'd1;
      end
      if (latch_end) begin
        pixel <= '0;
        frame <= frame + 5'd1;
        if (commit_now) begin
          gen_frames <= '0;
          gen_count  <= gen_count + 16'd1;
        end else if (gen_frames < GF_LAST) begin
          gen_frames <= gen_frames + GF_W'(1);
        end
      end
      // Leaving COMMIT clears the request, swallowing any step seen during it
      if (state == COMMIT) begin
        step_pending <= 1'b0;
      end else if (step) begin
        step_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_life_frame_scheduler.sv
// Directed bench for life_frame_scheduler with small timing parameters.
// Cycle k is the interval after the k-th rising edge following reset release
// (cycle 0 is the FETCH cycle); outputs are sampled on falling edges.
`timescale 1ns/1ps

module tb_life_frame_scheduler;

  localparam int NP  = 64;
  localparam int PC  = 4;
  localparam int LC  = 10;
  localparam int FPG = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        step;
  logic [5:0]  pixel;
  logic [4:0]  frame;
  logic        load_sreg;
  logic        transmit_pixel;
  logic        latching;
  logic        frame_done;
  logic        commit_gen;
  logic [15:0] gen_count;

  int tests_run    = 0;
  int tests_failed = 0;

  life_frame_scheduler #(
    .NUM_PIXELS    (NP),
    .PIXEL_CYCLES  (PC),
    .LATCH_CYCLES  (LC),
    .FRAMES_PER_GEN(FPG)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .step          (step),
    .pixel         (pixel),
    .frame         (frame),
    .load_sreg     (load_sreg),
    .transmit_pixel(transmit_pixel),
    .latching      (latching),
    .frame_done    (frame_done),
    .commit_gen    (commit_gen),
    .gen_count     (gen_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Hold reset for a few cycles, then release on a falling edge (cycle 0)
  task automatic do_reset();
    rst  = 1'b1;
    run  = 1'b0;
    step = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Advance to the next falling edge at which frame_done is high, bounded
  task automatic wait_frame_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    if (!seen) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s: frame_done not seen within 1000 cycles", tag);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; step = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if ({pixel, frame, gen_count} !== 27'd0) begin
      tests_failed++;
      $display("FAIL reset_regs: pixel=%0d frame=%0d gen=%0d expected all 0", pixel, frame, gen_count);
    end
    tests_run++;
    if ({load_sreg, transmit_pixel, latching, frame_done, commit_gen} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_pulses: got %b expected 00000",
               {load_sreg, transmit_pixel, latching, frame_done, commit_gen});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if (load_sreg !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_fetch_cycle: load_sreg=%b expected 0", load_sreg);
    end
    @(negedge clk);
    tests_run++;
    if (load_sreg !== 1'b1 || pixel !== 6'd0) begin
      tests_failed++;
      $display("FAIL reset_first_load: load_sreg=%b pixel=%0d expected 1/0", load_sreg, pixel);
    end
    @(negedge clk);
    tests_run++;
    if (transmit_pixel !== 1'b1 || load_sreg !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_first_tx: transmit=%b load=%b expected 1/0", transmit_pixel, load_sreg);
    end
  endtask

  // One full frame with run=0, every output compared cycle by cycle
  task automatic test_frame();
    int bad_load = 0, bad_tx = 0, bad_latch = 0, bad_fd = 0;
    int bad_commit = 0, bad_pix = 0, bad_frame = 0, bad_excl = 0;
    do_reset();
    for (int k = 1; k <= 395; k++) begin
      logic       e_load, e_tx, e_latch, e_fd;
      logic [5:0] e_pix;
      logic [4:0] e_frame;
      @(negedge clk);
      e_load  = (k <= 383 && k % 6 == 1) || k == 395;
      e_tx    = (k <= 383 && k % 6 == 2);
      e_latch = (k >= 384 && k <= 393);
      e_fd    = (k == 393);
      e_pix   = (k <= 383) ? 6'(k / 6) : (k <= 393) ? 6'd63 : 6'd0;
      e_frame = (k <= 393) ? 5'd0 : 5'd1;
      if (load_sreg !== e_load)      bad_load++;
      if (transmit_pixel !== e_tx)   bad_tx++;
      if (latching !== e_latch)      bad_latch++;
      if (frame_done !== e_fd)       bad_fd++;
      if (commit_gen !== 1'b0)       bad_commit++;
      if (pixel !== e_pix)           bad_pix++;
      if (frame !== e_frame)         bad_frame++;
      if ($countones({load_sreg, transmit_pixel, frame_done, commit_gen}) > 1) bad_excl++;
    end
    tests_run++;
    if (bad_load != 0) begin tests_failed++; $display("FAIL frame_load: %0d bad cycles, expected 0", bad_load); end
    tests_run++;
    if (bad_tx != 0) begin tests_failed++; $display("FAIL frame_tx: %0d bad cycles, expected 0", bad_tx); end
    tests_run++;
    if (bad_latch != 0) begin tests_failed++; $display("FAIL frame_latching: %0d bad cycles, expected 0", bad_latch); end
    tests_run++;
    if (bad_fd != 0) begin tests_failed++; $display("FAIL frame_done_393: %0d bad cycles, expected 0", bad_fd); end
    tests_run++;
    if (bad_commit != 0) begin tests_failed++; $display("FAIL frame_no_commit: %0d commit cycles, expected 0", bad_commit); end
    tests_run++;
    if (bad_pix != 0) begin tests_failed++; $display("FAIL frame_pixel: %0d bad cycles, expected 0", bad_pix); end
    tests_run++;
    if (bad_frame != 0) begin tests_failed++; $display("FAIL frame_counter: %0d bad cycles, expected 0", bad_frame); end
    tests_run++;
    if (bad_excl != 0) begin tests_failed++; $display("FAIL frame_exclusive: %0d overlapping cycles, expected 0", bad_excl); end
  endtask

  // run=1: commits after frames 2 and 4; the committing frame is one cycle longer
  task automatic test_run();
    int fd_cyc[4];
    int n_fd = 0, bad_commit = 0, n_commit = 0, bad_ctx = 0;
    logic [15:0] gen_at_788 = 16'hxxxx;
    do_reset();
    run = 1'b1;
    for (int k = 1; k <= 1580; k++) begin
      @(negedge clk);
      if (frame_done) begin
        if (n_fd < 4) fd_cyc[n_fd] = k;
        n_fd++;
      end
      if (commit_gen !== (k == 788 || k == 1577)) bad_commit++;
      if (commit_gen === 1'b1) begin
        n_commit++;
        if (latching !== 1'b0 || pixel !== 6'd0 || transmit_pixel !== 1'b0) bad_ctx++;
      end
      if (k == 788) gen_at_788 = gen_count;
    end
    run = 1'b0;
    tests_run++;
    if (n_fd != 4 || bad_commit != 0 || n_commit != 2) begin
      tests_failed++;
      $display("FAIL run_commits: frames=%0d commits=%0d bad=%0d expected 4/2/0", n_fd, n_commit, bad_commit);
    end
    tests_run++;
    if (n_fd >= 4 && (fd_cyc[1] - fd_cyc[0] != 394 || fd_cyc[2] - fd_cyc[1] != 395)) begin
      tests_failed++;
      $display("FAIL run_period: periods %0d/%0d expected 394/395",
               fd_cyc[1] - fd_cyc[0], fd_cyc[2] - fd_cyc[1]);
    end
    tests_run++;
    if (gen_at_788 !== 16'd1 || gen_count !== 16'd2) begin
      tests_failed++;
      $display("FAIL run_gen_count: at_commit=%0d final=%0d expected 1/2", gen_at_788, gen_count);
    end
    tests_run++;
    if (bad_ctx != 0) begin
      tests_failed++;
      $display("FAIL run_commit_idle: %0d commit cycles not idle, expected 0", bad_ctx);
    end
  endtask

  // run=0 with three step pulses in frame 1: one commit at cycle 394
  task automatic test_multi_step();
    int n_commit = 0, commit_at = -1;
    do_reset();
    for (int k = 1; k <= 800; k++) begin
      @(negedge clk);
      if (commit_gen === 1'b1) begin
        n_commit++;
        commit_at = k;
      end
      step = (k == 50 || k == 120 || k == 200);
    end
    step = 1'b0;
    tests_run++;
    if (n_commit != 1 || commit_at != 394) begin
      tests_failed++;
      $display("FAIL multi_step_commit: commits=%0d at=%0d expected 1 at 394", n_commit, commit_at);
    end
    tests_run++;
    if (gen_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL multi_step_gen: gen_count=%0d expected 1", gen_count);
    end
  endtask

  // Step coinciding with a run-triggered commit: one commit, no leftover request
  task automatic test_step_last_latch();
    int n_commit = 0, commit_at = -1;
    do_reset();
    run = 1'b1;
    for (int k = 1; k <= 1400; k++) begin
      @(negedge clk);
      if (commit_gen === 1'b1) begin
        n_commit++;
        commit_at = k;
      end
      step = (k == 787);
    end
    step = 1'b0;
    run  = 1'b0;
    tests_run++;
    if (n_commit != 1 || commit_at != 788) begin
      tests_failed++;
      $display("FAIL step_last_latch: commits=%0d at=%0d expected 1 at 788", n_commit, commit_at);
    end
    tests_run++;
    if (gen_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL step_last_latch_gen: gen_count=%0d expected 1", gen_count);
    end
  endtask

  // Step in the last LATCH cycle then in the COMMIT cycle: the second is absorbed
  task automatic test_back_to_back();
    int n_commit = 0, commit_at = -1;
    do_reset();
    for (int k = 1; k <= 1200; k++) begin
      @(negedge clk);
      if (commit_gen === 1'b1) begin
        n_commit++;
        commit_at = k;
      end
      step = (k == 393 || k == 394);
    end
    step = 1'b0;
    tests_run++;
    if (n_commit != 1 || commit_at != 394 || gen_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL back_to_back: commits=%0d at=%0d gen=%0d expected 1 at 394 gen 1",
               n_commit, commit_at, gen_count);
    end
  endtask

  // Frame counter wraps 31->0; gen_count wraps 0xFFFF->0 via step commits
  task automatic test_wrap();
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 31; i++) wait_frame_done("wrap_frames");
    @(negedge clk);
    tests_run++;
    if (frame !== 5'd31) begin
      tests_failed++;
      $display("FAIL wrap_frame31: frame=%0d expected 31", frame);
    end
    wait_frame_done("wrap_frame32");
    @(negedge clk);
    tests_run++;
    if (frame !== 5'd0) begin
      tests_failed++;
      $display("FAIL wrap_frame0: frame=%0d expected 0", frame);
    end
    run = 1'b0;
    repeat (5) @(negedge clk);
    force dut.gen_count = 16'hFFFE;
    #1;
    release dut.gen_count;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    wait_frame_done("wrap_gen1");
    @(negedge clk);
    tests_run++;
    if (commit_gen !== 1'b1 || gen_count !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL wrap_gen_ffff: commit=%b gen=%h expected 1/ffff", commit_gen, gen_count);
    end
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    wait_frame_done("wrap_gen2");
    @(negedge clk);
    tests_run++;
    if (commit_gen !== 1'b1 || gen_count !== 16'h0000) begin
      tests_failed++;
      $display("FAIL wrap_gen_zero: commit=%b gen=%h expected 1/0000", commit_gen, gen_count);
    end
  endtask

  // Reset during SEND of pixel 37 in frame 1 aborts at once
  task automatic test_reset_mid_send();
    int bad_quiet = 0;
    do_reset();
    repeat (619) @(negedge clk);
    tests_run++;
    if (pixel !== 6'd37 || frame !== 5'd1 || latching !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_send_setup: pixel=%0d frame=%0d expected 37/1", pixel, frame);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (pixel !== 6'd0 || frame !== 5'd0 || gen_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL mid_send_abort: pixel=%0d frame=%0d gen=%0d expected 0/0/0", pixel, frame, gen_count);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if ({load_sreg, transmit_pixel, latching, frame_done, commit_gen} !== 5'b0) bad_quiet++;
    end
    rst = 1'b0;
    #1;
    if (load_sreg !== 1'b0) bad_quiet++;
    tests_run++;
    if (bad_quiet != 0) begin
      tests_failed++;
      $display("FAIL mid_send_quiet: %0d cycles with pulses, expected 0", bad_quiet);
    end
    @(negedge clk);
    tests_run++;
    if (load_sreg !== 1'b1 || pixel !== 6'd0) begin
      tests_failed++;
      $display("FAIL mid_send_restart: load=%b pixel=%0d expected 1/0", load_sreg, pixel);
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; step = 1'b0;
    test_reset();
    test_frame();
    test_run();
    test_multi_step();
    test_step_last_latch();
    test_back_to_back();
    test_wrap();
    test_reset_mid_send();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
